// File: rtl/aliens_io_ctrl.sv
// I/O controller: CPU-visible bank/coin/sound registers with a write strobe edge detector,
// sound-CPU handshake, and a vblank-driven watchdog that pulses a CPU reset request.
module aliens_io_ctrl #(
  parameter int unsigned WDOG_LIMIT = 16,
  parameter int unsigned WDOG_PULSE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       rnw,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       vblank,
  input  logic       snd_ack,
  output logic [4:0] rom_bank,
  output logic [1:0] coin_cnt,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       wdog_rst
);

  localparam int unsigned CW = $clog2(WDOG_LIMIT + 1);
  localparam int unsigned PW = (WDOG_PULSE > 1) ? $clog2(WDOG_PULSE) : 1;

  typedef enum logic {
    WD_COUNT = 1'b0,
    WD_FIRE  = 1'b1
  } wd_state_e;

  logic          cs_prev_q,   cs_prev_d;
  logic          wr_arm_q,    wr_arm_d;
  logic [4:0]    rom_bank_q,  rom_bank_d;
  logic [1:0]    coin_cnt_q,  coin_cnt_d;
  logic [7:0]    snd_latch_q, snd_latch_d;
  logic          snd_irq_q,   snd_irq_d;
  logic          ack_s1_q,    ack_s1_d;
  logic          ack_s2_q,    ack_s2_d;
  logic          ack_s3_q,    ack_s3_d;
  logic          vblank_q,    vblank_d;
  wd_state_e     wd_state_q,  wd_state_d;
  logic [CW-1:0] wd_cnt_q,    wd_cnt_d;
  logic [PW-1:0] pulse_q,     pulse_d;
  logic          wdog_rst_q,  wdog_rst_d;

  logic wr_stb_c;
  logic kick_c;
  logic ack_edge_c;
  logic vb_edge_c;

  // wr_arm_q blocks a write left pending across reset until cs_n is seen high once.
  assign wr_stb_c   = cen && !cs_n && !rnw && cs_prev_q && wr_arm_q;
  assign kick_c     = wr_stb_c && (addr == 2'd3);
  assign ack_edge_c = ack_s2_q && !ack_s3_q;
  assign vb_edge_c  = vblank && !vblank_q;

  always_comb begin
    cs_prev_d   = cs_prev_q;
    wr_arm_d    = wr_arm_q;
    rom_bank_d  = rom_bank_q;
    coin_cnt_d  = coin_cnt_q;
    snd_latch_d = snd_latch_q;
    snd_irq_d   = snd_irq_q;
    ack_s1_d    = snd_ack;
    ack_s2_d    = ack_s1_q;
    ack_s3_d    = ack_s2_q;
    vblank_d    = vblank;
    wd_state_d  = wd_state_q;
    wd_cnt_d    = wd_cnt_q;
    pulse_d     = pulse_q;
    wdog_rst_d  = wdog_rst_q;

    if (cen) begin
      cs_prev_d = cs_n;
      if (cs_n) wr_arm_d = 1'b1;
    end

    // Ack clear first so a coincident addr-2 write overrides it.
    if (ack_edge_c) snd_irq_d = 1'b0;

    if (wr_stb_c) begin
      case (addr)
        2'd0: rom_bank_d = din[4:0];
        2'd1: coin_cnt_d = din[1:0];
        2'd2: begin
          snd_latch_d = din;
          snd_irq_d   = 1'b1;
        end
        default: ;
      endcase
    end

    case (wd_state_q)
      WD_COUNT: begin
        wdog_rst_d = 1'b0;
        if (wd_cnt_q == CW'(WDOG_LIMIT)) begin
          wd_state_d = WD_FIRE;
          wdog_rst_d = 1'b1;
          pulse_d    = '0;
        end else if (kick_c) begin
          wd_cnt_d = '0;
        end else if (vb_edge_c) begin
          wd_cnt_d = CW'(wd_cnt_q + 1'b1);
        end
      end
      WD_FIRE: begin
        if (pulse_q == PW'(WDOG_PULSE - 1)) begin
          wd_state_d = WD_COUNT;
          wdog_rst_d = 1'b0;
          wd_cnt_d   = '0;
        end else begin
          pulse_d    = PW'(pulse_q + 1'b1);
          wdog_rst_d = 1'b1;
        end
      end
      default: begin
        wd_state_d = WD_COUNT;
        wdog_rst_d = 1'b0;
        wd_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_prev_q   <= 1'b1;
      wr_arm_q    <= 1'b0;
      rom_bank_q  <= '0;
      coin_cnt_q  <= '0;
      snd_latch_q <= '0;
      snd_irq_q   <= 1'b0;
      ack_s1_q    <= 1'b0;
      ack_s2_q    <= 1'b0;
      ack_s3_q    <= 1'b0;
      vblank_q    <= 1'b0;
      wd_state_q  <= WD_COUNT;
      wd_cnt_q    <= '0;
      pulse_q     <= '0;
      wdog_rst_q  <= 1'b0;
    end else begin
      cs_prev_q   <= cs_prev_d;
      wr_arm_q    <= wr_arm_d;
      rom_bank_q  <= rom_bank_d;
      coin_cnt_q  <= coin_cnt_d;
      snd_latch_q <= snd_latch_d;
      snd_irq_q   <= snd_irq_d;
      ack_s1_q    <= ack_s1_d;
      ack_s2_q    <= ack_s2_d;
      ack_s3_q    <= ack_s3_d;
      vblank_q    <= vblank_d;
      wd_state_q  <= wd_state_d;
      wd_cnt_q    <= wd_cnt_d;
      pulse_q     <= pulse_d;
      wdog_rst_q  <= wdog_rst_d;
    end
  end

  // Read mux; unmapped or deselected reads float high like an undriven bus.
  always_comb begin
    dout = 8'hFF;
    if (!cs_n && rnw) begin
      case (addr)
        2'd0:    dout = {3'b000, rom_bank_q};
        2'd2:    dout = {7'b0, snd_irq_q};
        default: dout = 8'hFF;
      endcase
    end
  end

  assign rom_bank  = rom_bank_q;
  assign coin_cnt  = coin_cnt_q;
  assign snd_latch = snd_latch_q;
  assign snd_irq   = snd_irq_q;
  assign wdog_rst  = wdog_rst_q;

endmodule

// File: tb/tb_aliens_io_ctrl.sv
// Directed bench for aliens_io_ctrl: register writes, reads, sound handshake,
// watchdog firing/kicking and reset behaviour, with hand-computed expectations.
module tb_aliens_io_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       cs_n;
  logic       rnw;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       vblank;
  logic       snd_ack;
  logic [4:0] rom_bank;
  logic [1:0] coin_cnt;
  logic [7:0] snd_latch;
  logic       snd_irq;
  logic       wdog_rst;

  int checks   = 0;
  int failures = 0;

  aliens_io_ctrl #(.WDOG_LIMIT(16), .WDOG_PULSE(64)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .rnw(rnw), .addr(addr),
    .din(din), .dout(dout), .vblank(vblank), .snd_ack(snd_ack),
    .rom_bank(rom_bank), .coin_cnt(coin_cnt), .snd_latch(snd_latch),
    .snd_irq(snd_irq), .wdog_rst(wdog_rst)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs_n = 1'b0; rnw = 1'b0; addr = a; din = d;
    tick();
    cs_n = 1'b1; rnw = 1'b1;
    tick();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs_n = 1'b0; rnw = 1'b1; addr = a;
    #1;
    d = dout;
    tick();
    cs_n = 1'b1;
    tick();
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic       seen;
    int         n;

    rst = 1'b1; cen = 1'b1; cs_n = 1'b1; rnw = 1'b1; addr = 2'd0; din = 8'h00;
    vblank = 1'b0; snd_ack = 1'b0;
    tick(); tick();
    check_eq("rst_rom_bank", 32'(rom_bank), 32'h0);
    check_eq("rst_coin_cnt", 32'(coin_cnt), 32'h0);
    check_eq("rst_snd_latch", 32'(snd_latch), 32'h0);
    check_eq("rst_snd_irq", 32'(snd_irq), 32'h0);
    check_eq("rst_wdog_rst", 32'(wdog_rst), 32'h0);
    check_eq("rst_dout_idle", 32'(dout), 32'hFF);
    rst = 1'b0;
    tick(); tick();

    // Bank write held for 3 bus phases; later din changes must not be taken
    cs_n = 1'b0; rnw = 1'b0; addr = 2'd0; din = 8'hF3;
    tick();
    check_eq("bank_first_phase", 32'(rom_bank), 32'h13);
    din = 8'h05;
    tick(); tick();
    check_eq("bank_written_once", 32'(rom_bank), 32'h13);
    cs_n = 1'b1; rnw = 1'b1;
    tick();
    bus_read(2'd0, rd);
    check_eq("read_addr0", 32'(rd), 32'h13);

    bus_write(2'd1, 8'hFE);
    check_eq("coin_cnt", 32'(coin_cnt), 32'h2);
    bus_read(2'd1, rd);
    check_eq("read_addr1", 32'(rd), 32'hFF);
    bus_read(2'd3, rd);
    check_eq("read_addr3", 32'(rd), 32'hFF);

    // No bus phase while cen=0
    cen = 1'b0; cs_n = 1'b0; rnw = 1'b0; addr = 2'd0; din = 8'h07;
    tick(); tick();
    check_eq("cen_gated", 32'(rom_bank), 32'h13);
    cs_n = 1'b1; rnw = 1'b1;
    cen = 1'b1;
    tick();

    // Write with rnw low but reading dout: deselected write phase reads FF
    cs_n = 1'b0; rnw = 1'b0; addr = 2'd0;
    #1;
    check_eq("dout_on_write", 32'(dout), 32'hFF);
    cs_n = 1'b1; rnw = 1'b1;
    tick();
    check_eq("dout_write_no_effect", 32'(rom_bank), 32'h13);

    // Sound handshake
    bus_write(2'd2, 8'hA5);
    check_eq("snd_latch", 32'(snd_latch), 32'hA5);
    check_eq("snd_irq_set", 32'(snd_irq), 32'h1);
    bus_read(2'd2, rd);
    check_eq("read_addr2", 32'(rd), 32'h01);
    check_eq("read_no_side_effect", 32'(snd_irq), 32'h1);
    snd_ack = 1'b1;
    tick(); tick(); tick();
    check_eq("snd_irq_cleared", 32'(snd_irq), 32'h0);
    snd_ack = 1'b0;
    tick(); tick(); tick();

    // Coincidence: write lands on the cycle the synchronised ack edge is seen
    bus_write(2'd2, 8'h11);
    check_eq("coin_pre_irq", 32'(snd_irq), 32'h1);
    snd_ack = 1'b1;
    tick(); tick();
    cs_n = 1'b0; rnw = 1'b0; addr = 2'd2; din = 8'h5A;
    tick();
    check_eq("coincide_irq", 32'(snd_irq), 32'h1);
    check_eq("coincide_latch", 32'(snd_latch), 32'h5A);
    cs_n = 1'b1; rnw = 1'b1;
    tick(); tick();
    check_eq("coincide_irq_holds", 32'(snd_irq), 32'h1);
    snd_ack = 1'b0;
    tick(); tick();

    // Kick every 15 vblank edges: watchdog never fires
    seen = 1'b0;
    bus_write(2'd3, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 15; e++) begin
        vb_pulse();
        seen = seen | wdog_rst;
      end
      bus_write(2'd3, 8'hAA);
      seen = seen | wdog_rst;
    end
    check_eq("kick_no_fire", 32'(seen), 32'h0);

    // Kick and vblank edge on the same cycle: kick wins
    vblank = 1'b1;
    cs_n = 1'b0; rnw = 1'b0; addr = 2'd3;
    tick();
    vblank = 1'b0; cs_n = 1'b1; rnw = 1'b1;
    tick();
    for (int e = 0; e < 15; e++) vb_pulse();
    check_eq("kick_wins_no_fire", 32'(wdog_rst), 32'h0);
    vblank = 1'b1;
    tick();
    check_eq("edge16_not_yet", 32'(wdog_rst), 32'h0);
    vblank = 1'b0;
    tick();
    check_eq("fire_asserted", 32'(wdog_rst), 32'h1);
    n = 0;
    while (wdog_rst && n < 200) begin
      n++;
      tick();
    end
    check_eq("fire_width", 32'(n), 32'd64);
    check_eq("fire_released", 32'(wdog_rst), 32'h0);

    // Counting restarts from 0 after FIRE
    for (int e = 0; e < 15; e++) vb_pulse();
    check_eq("post_fire_15", 32'(wdog_rst), 32'h0);
    vb_pulse();
    check_eq("post_fire_16", 32'(wdog_rst), 32'h1);
    tick(); tick(); tick();

    // Reset mid-FIRE with a write pending
    cs_n = 1'b0; rnw = 1'b0; addr = 2'd0; din = 8'h1F;
    rst = 1'b1;
    #1;
    check_eq("midfire_wdog", 32'(wdog_rst), 32'h0);
    check_eq("midfire_bank", 32'(rom_bank), 32'h0);
    check_eq("midfire_coin", 32'(coin_cnt), 32'h0);
    check_eq("midfire_latch", 32'(snd_latch), 32'h0);
    check_eq("midfire_irq", 32'(snd_irq), 32'h0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check_eq("held_cs_no_write", 32'(rom_bank), 32'h0);
    cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    tick();
    check_eq("rearmed_write", 32'(rom_bank), 32'h1F);
    cs_n = 1'b1; rnw = 1'b1;
    tick();

    for (int e = 0; e < 15; e++) vb_pulse();
    check_eq("post_rst_15", 32'(wdog_rst), 32'h0);
    vb_pulse();
    check_eq("post_rst_16", 32'(wdog_rst), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aliens_io_ctrl.md
ALIENS_IO_CTRL -- requirements
Module: aliens_io_ctrl

Interface
REQ-001 Parameter WDOG_LIMIT, default 16: number of vblank rising edges without a kick before the watchdog fires.
REQ-002 Parameter WDOG_PULSE, default 64: width of wdog_rst, in clk cycles.
REQ-003 clk  in  1  single system clock; all state is on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cen  in  1  CPU bus-cycle clock enable; bus inputs are sampled only when cen=1.
REQ-006 cs_n  in  1  active-low I/O chip select from the upstream address-decode PAL.
REQ-007 rnw  in  1  CPU read-not-write.
REQ-008 addr  in  2  register select (CPU A1:A0).
REQ-009 din  in  8  CPU write data.
REQ-010 dout  out  8  CPU read data.
REQ-011 vblank  in  1  video vertical blank, synchronous to clk.
REQ-012 snd_ack  in  1  sound-CPU acknowledge, asynchronous to clk.
REQ-013 rom_bank  out  5  program-ROM bank select.
REQ-014 coin_cnt  out  2  coin counter drives.
REQ-015 snd_latch  out  8  sound command byte.
REQ-016 snd_irq  out  1  sound-CPU interrupt request, active-high.
REQ-017 wdog_rst  out  1  CPU reset request, active-high.

Function
REQ-018 A bus phase SHALL exist when cen=1; the block SHALL register cs_n into cs_prev on each bus phase.
REQ-019 A write strobe SHALL occur on a bus phase with cs_n=0, rnw=0, cs_prev=1: exactly one write per chip-select assertion, regardless of assertion length.
REQ-020 Write to addr 0 SHALL load rom_bank<=din[4:0] on the clk after the strobe.
REQ-021 Write to addr 1 SHALL load coin_cnt<=din[1:0].
REQ-022 Write to addr 2 SHALL load snd_latch<=din and set snd_irq=1.
REQ-023 Write to addr 3 SHALL kick the watchdog; din is ignored.
REQ-024 snd_ack SHALL be synchronised through two flops; a rising edge of the synchronised signal SHALL clear snd_irq.
REQ-025 If an addr-2 write and a synchronised ack edge coincide, set SHALL win (snd_irq=1).
REQ-026 dout SHALL be combinational.
REQ-027 With cs_n=0 and rnw=1, dout SHALL be {3'b000,rom_bank} for addr 0, {7'b0,snd_irq} for addr 2, and 8'hFF for addr 1 and 3.
REQ-028 In every other condition, dout SHALL be 8'hFF.
REQ-029 Reads SHALL have no side effects.
REQ-030 Watchdog states SHALL be COUNT and FIRE; reset state is COUNT with wd_cnt=0.
REQ-031 COUNT: each vblank rising edge (vblank=1, previous clk vblank=0) SHALL increment wd_cnt.
REQ-032 COUNT: a kick SHALL clear wd_cnt to 0.
REQ-033 COUNT: a kick coinciding with a vblank edge SHALL leave wd_cnt=0 (kick wins).
REQ-034 COUNT: when wd_cnt reaches WDOG_LIMIT, the block SHALL enter FIRE on the next clk.
REQ-035 FIRE: wdog_rst=1 for exactly WDOG_PULSE clks.
REQ-036 FIRE: vblank edges and kicks SHALL be ignored.
REQ-037 FIRE exit: the block SHALL return to COUNT with wd_cnt=0.
REQ-038 wdog_rst SHALL be registered, and SHALL be 0 in COUNT.
REQ-039 wd_cnt SHALL be sized ceil(log2(WDOG_LIMIT+1)) bits and SHALL never wrap.
REQ-040 wdog_rst SHALL NOT reset any register in this block.

Reset
REQ-041 While rst=1, the block SHALL asynchronously hold: rom_bank=0, coin_cnt=0, snd_latch=0, snd_irq=0, wdog_rst=0, watchdog=COUNT, wd_cnt=0, cs_prev=1, ack sync flops=0, vblank history=0.
REQ-042 rst asserted mid-FIRE SHALL drop wdog_rst immediately; after release, counting SHALL restart from 0.
REQ-043 rst asserted mid-write SHALL suppress that write; a still-low cs_n after release SHALL NOT produce a strobe until cs_n has been seen high.

Verification
REQ-044 Bank write: cs_n low for 3 bus phases, rnw=0, addr=0, din=8'hF3 -> rom_bank=5'h13 one clk after first phase; register written once; read addr 0 returns 8'h13.
REQ-045 Sound handshake: write addr 2 din=8'hA5 -> snd_latch=8'hA5, snd_irq=1, read addr 2 returns 8'h01; pulse snd_ack -> snd_irq=0 within 3 clks.
REQ-046 Coincidence: addr-2 write on the same clk as the synchronised ack edge -> snd_irq remains 1.
REQ-047 Watchdog with defaults: 16 vblank edges without kick -> wdog_rst=1 for exactly 64 clks, then 0 and wd_cnt=0; kick every 15 edges -> wdog_rst never asserts.
REQ-048 Reset: assert rst during FIRE and with cs_n held low -> all outputs at reset values immediately, and no write occurs after release until cs_n toggles high then low.
